// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, types and write-port arbitration for regfile_mp (ports: none)
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int REG_AW = $clog2(NREGS);
  localparam int MAX_WR = 4;
  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] reg_data_t;
  function automatic logic [1:0] pick_wr(input logic [MAX_WR-1:0] match);
    pick_wr = '0;
    for (int j = 0; j < MAX_WR; j++) if (match[j]) pick_wr = 2'(j);
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: busy bits per register (clk, rst, rs_addr -> rs_busy, rd_wren/rd_addr clear, alloc_en/alloc_addr set, busy_vec state)
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter bit BYPASS = 1,
  parameter bit ZERO_REG = 1,
  parameter int AW = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rs_addr,
  output logic [NUM_RD-1:0]    rs_busy,
  input  logic [NUM_WR-1:0]    rd_wren,
  input  logic [NUM_WR*AW-1:0] rd_addr,
  input  logic                 alloc_en,
  input  logic [AW-1:0]        alloc_addr,
  output logic [NUM_REGS-1:0]  busy_vec
);
  logic [NUM_REGS-1:0] r_busy, w_clr, w_set;
  logic [AW-1:0] w_ra [NUM_RD];
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int j = 0; j < NUM_WR; j++) if (rd_wren[j]) w_clr[rd_addr[j*AW +: AW]] = 1'b1;
    w_set[alloc_addr] = alloc_en;
    if (ZERO_REG) w_set[0] = 1'b0;
    rs_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_ra[i] = rs_addr[i*AW +: AW];
      // a same-cycle write retires the producer unless a new one is allocated alongside it
      rs_busy[i] = (BYPASS && !rst && w_clr[w_ra[i]]) ? w_set[w_ra[i]] : r_busy[w_ra[i]];
    end
  end
  always_ff @(posedge clk) r_busy <= rst ? '0 : (r_busy & ~w_clr) | w_set;
  assign busy_vec = r_busy;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with bypass, zero register and busy scoreboard (clk, rst; rs_addr -> rs_data/rs_busy; rd_wren/rd_addr/rd_data writes; alloc_en/alloc_addr; busy_vec)
module regfile_mp import regfile_pkg::*; #(
  parameter int DATA_W = XLEN,
  parameter int NUM_REGS = NREGS,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter bit BYPASS = 1,
  parameter bit ZERO_REG = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*AW-1:0]     rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic [NUM_WR-1:0]        rd_wren,
  input  logic [NUM_WR*AW-1:0]     rd_addr,
  input  logic [NUM_WR*DATA_W-1:0] rd_data,
  input  logic                     alloc_en,
  input  logic [AW-1:0]            alloc_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic [MAX_WR-1:0] w_match [NUM_REGS];
  logic [DATA_W-1:0] w_wdata [NUM_REGS];
  logic [AW-1:0] w_ra [NUM_RD];
  // per-register write match and winning data, shared by the write and bypass paths
  always_comb begin
    for (int a = 0; a < NUM_REGS; a++) begin
      w_match[a] = '0;
      for (int j = 0; j < NUM_WR; j++) w_match[a][j] = rd_wren[j] && rd_addr[j*AW +: AW] == AW'(a);
      w_wdata[a] = rd_data[32'(pick_wr(w_match[a])) * DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge clk)
    if (rst) for (int a = 0; a < NUM_REGS; a++) r_mem[a] <= '0;
    else for (int a = 0; a < NUM_REGS; a++) if (|w_match[a] && !(ZERO_REG && a == 0)) r_mem[a] <= w_wdata[a];
  always_comb begin
    rs_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      w_ra[i] = rs_addr[i*AW +: AW];
      rs_data[i*DATA_W +: DATA_W] = (ZERO_REG && w_ra[i] == '0) ? '0
        : (BYPASS && !rst && |w_match[w_ra[i]]) ? w_wdata[w_ra[i]] : r_mem[w_ra[i]];
    end
  end
  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR),
    .BYPASS(BYPASS), .ZERO_REG(ZERO_REG), .AW(AW)
  ) u_sb (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_busy(rs_busy),
    .rd_wren(rd_wren), .rd_addr(rd_addr), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .busy_vec(busy_vec)
  );
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write, two-read regfile in the core datapath.
- Generalised in data width, register count, read-port count and write-port count.
- Adds features the current regfile lacks: optional write-to-read bypass, optional hardwired-zero register, and a per-register busy scoreboard (alloc/commit) so a future pipelined core can detect RAW hazards without an external table.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of read ports.
- NUM_WR, 1, number of write ports, 1..4.
- BYPASS, 1, 1 = a read that matches a same-cycle write returns the write data; 0 = the read returns the stored value.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and allocs.
- AW (localparam), $clog2(NUM_REGS), address width.

Ports:
- clk  in  1  single clock; everything updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- rs_addr  in  NUM_RD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rs_data  out  NUM_RD*DATA_W  read data, combinational.
- rs_busy  out  NUM_RD  busy flag of the addressed register, combinational.
- rd_wren  in  NUM_WR  write enables.
- rd_addr  in  NUM_WR*AW  write addresses.
- rd_data  in  NUM_WR*DATA_W  write data.
- alloc_en  in  1  mark a register busy (pending producer).
- alloc_addr  in  AW  register to mark busy.
- busy_vec  out  NUM_REGS  full scoreboard, registered.

Behaviour:
- Reset: when rst=1 at a clk edge, every register clears to 0 and every busy bit clears to 0. Reset overrides all same-cycle writes and allocs. rs_data therefore reads 0 and busy_vec reads 0 the cycle after reset.
- Write: when rd_wren[j]=1, reg[rd_addr[j]] <= rd_data[j] at the edge. Write latency is 1 cycle; the stored value is visible the next cycle without bypass.
- Write conflict: if several ports write the same address in the same cycle, the highest-indexed port wins. No error flag is raised.
- ZERO_REG=1: writes and allocs to address 0 are ignored. Reading address 0 returns 0 with busy=0, regardless of BYPASS.
- Read: rs_data[i] = reg[rs_addr[i]], combinational, with no read latency.
- Bypass (BYPASS=1): if any enabled write port targets rs_addr[i] in the current cycle, rs_data[i] returns that port's rd_data. The highest-indexed matching port wins, consistent with the write-conflict rule.
- Bypass and reset: bypass is suppressed while rst=1, and rs_data shows stored values.
- Scoreboard:
  - alloc_en=1 sets busy[alloc_addr] at the edge.
  - Any enabled write to address a clears busy[a] at the edge.
  - Simultaneous alloc and write to the same address: the data is written and the busy bit stays 1 (the newer producer wins).
- rs_busy[i] = busy_vec[rs_addr[i]] (registered value). When BYPASS=1 and a write to that address is active this cycle, rs_busy[i] reads 0 unless alloc_en targets the same address in that cycle.
- Allocating an already-busy register keeps it busy.
- Writing a non-busy register is legal and leaves it non-busy.
- Addresses are always in range because NUM_REGS is a power of two; no wrap handling is needed.

Decomposition:
- Package regfile_pkg:
  - default constants XLEN=32, NREGS=32.
  - typedef reg_addr_t (logic [AW-1:0]).
  - typedef reg_data_t (logic [XLEN-1:0]).
  - function pick_wr(), which returns the winning write port index for a given address (used by both the write path and the bypass path).
- One sub-module: regfile_scoreboard. It holds the busy-vector state, alloc/clear logic, and the rs_busy lookup.
- The storage array and the read/bypass muxing stay in regfile_mp.

Test Plan:
- Reset clear: write 0xDEADBEEF to r5, then assert rst for 1 cycle → rs_data(r5)=0 and busy_vec=0 from the next cycle.
- Basic write/read: write 0x12345678 to r7 → the next cycle rs_data[0]=0x12345678. With BYPASS=1 it is also visible in the same cycle; with BYPASS=0 the same-cycle read returns the old value 0.
- Zero register: write 0xFFFFFFFF to r0 with alloc r0 → r0 reads 0 and rs_busy=0 on every port.
- Write conflict (NUM_WR=2): ports 0 and 1 both write r3 with 0xAAAA0000 and 0xBBBB0000 → stored and bypassed value is 0xBBBB0000.
- Scoreboard: alloc r9 → busy_vec[9]=1 the next cycle; then write r9 with 0x55 → busy clears the next cycle. In the write cycle, rs_busy(r9)=0 and rs_data=0x55 (BYPASS=1).
- Alloc/write collision: alloc r4 and write r4=0x77 in the same cycle → the next cycle reg r4=0x77 and busy_vec[4]=1. Then 100 random write/read pairs are checked against a reference model.
